cmd_parser: RTL and testbench



---
 rtl/cmd_parser_pkg.sv | 47 ++++
 rtl/cmd_parser_rx_timeout.sv | 34 +++
 rtl/cmd_parser.sv | 174 +++++++++++++++++
 tb/tb_cmd_parser.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_parser_pkg                                               |
// | Description : Frame constants, opcodes, error codes and FSM states shared   |
// |               by the host command parser.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cmd_parser_pkg;

    localparam logic [7:0] CMD_HDR0 = 8'h5A;
    localparam logic [7:0] CMD_HDR1 = 8'hC3;

    localparam logic [7:0] OP_DUMP = 8'h01;
    localparam logic [7:0] OP_ARM  = 8'h02;
    localparam logic [7:0] OP_TRIG = 8'h03;

    localparam logic [2:0] ERR_BADOP   = 3'd1;
    localparam logic [2:0] ERR_CKSUM   = 3'd2;
    localparam logic [2:0] ERR_ZEROCNT = 3'd3;
    localparam logic [2:0] ERR_BUSY    = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    localparam int TIMEOUT_CYC_DEFAULT = 100000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_OP   = 3'd2,
        S_ARG  = 3'd3,
        S_CK   = 3'd4,
        S_EXEC = 3'd5
    } state_e;

    function automatic logic op_legal(input logic [7:0] op);
        return (op == OP_DUMP) || (op == OP_ARM) || (op == OP_TRIG);
    endfunction

    function automatic logic [2:0] op_nargs(input logic [7:0] op);
        case (op)
            OP_DUMP: return 3'd4;
            OP_TRIG: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_parser_rx_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_parser_rx_timeout                                        |
// | Description : Inter-byte watchdog; reloads on clear, counts down while     |
// |               enabled and flags expiry once TIMEOUT_CYC-1 cycles elapsed.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmd_parser_rx_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired_o = enable_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmd_parser                                                   |
// | Description : Parses framed, XOR-checksummed host commands into dump, arm  |
// |               and trigger controls; dropped frames raise a coded error.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int AW          = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          dump_busy_i,
    output logic          start_dump_o,
    output logic [AW-1:0] start_addr_o,
    output logic [15:0]   count_o,
    output logic          arm_o,
    output logic [7:0]    trig_mask_o,
    output logic [7:0]    trig_value_o,
    output logic          err_o,
    output logic [2:0]    err_code_o,
    output logic          parser_busy_o
);

    state_e        state_q;
    logic [7:0]    op_q;
    logic [7:0]    acc_q;
    logic [1:0]    idx_q;
    logic [7:0]    arg_q [4];
    logic          start_dump_q;
    logic [AW-1:0] start_addr_q;
    logic [15:0]   count_q;
    logic          arm_q;
    logic [7:0]    trig_mask_q;
    logic [7:0]    trig_value_q;
    logic          err_q;
    logic [2:0]    err_code_q;

    logic          waiting;
    logic          tmo_expired;
    logic [AW-1:0] dump_addr_d;
    logic [15:0]   dump_cnt_d;

    assign waiting     = (state_q == S_H1) || (state_q == S_OP) ||
                         (state_q == S_ARG) || (state_q == S_CK);
    // Address bytes wider than the buffer are truncated, not rejected.
    assign dump_addr_d = AW'({arg_q[1], arg_q[0]});
    assign dump_cnt_d  = {arg_q[3], arg_q[2]};

    cmd_parser_rx_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (rx_valid_i),
        .enable_i  (waiting),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            for (int i = 0; i < 4; i++) arg_q[i] <= '0;
            start_dump_q <= 1'b0;
            start_addr_q <= '0;
            count_q      <= '0;
            arm_q        <= 1'b0;
            trig_mask_q  <= 8'hFF;
            trig_value_q <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            start_dump_q <= 1'b0;
            arm_q        <= 1'b0;
            err_q        <= 1'b0;
            // A byte landing on the expiry cycle keeps the frame alive.
            if (!rx_valid_i && tmo_expired) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid_i && (rx_data_i == CMD_HDR0)) state_q <= S_H1;
                    end
                    S_H1: begin
                        if (rx_valid_i) begin
                            if (rx_data_i == CMD_HDR1)      state_q <= S_OP;
                            else if (rx_data_i != CMD_HDR0) state_q <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        if (rx_valid_i) begin
                            if (op_legal(rx_data_i)) begin
                                op_q    <= rx_data_i;
                                acc_q   <= rx_data_i;
                                idx_q   <= '0;
                                state_q <= (op_nargs(rx_data_i) != 3'd0) ? S_ARG : S_CK;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_BADOP;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                    S_ARG: begin
                        if (rx_valid_i) begin
                            arg_q[idx_q] <= rx_data_i;
                            acc_q        <= acc_q ^ rx_data_i;
                            idx_q        <= idx_q + 2'd1;
                            if ({1'b0, idx_q} == (op_nargs(op_q) - 3'd1)) state_q <= S_CK;
                        end
                    end
                    S_CK: begin
                        if (rx_valid_i) begin
                            if (rx_data_i != acc_q) begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_CKSUM;
                                state_q    <= S_IDLE;
                            end else begin
                                state_q <= S_EXEC;
                            end
                        end
                    end
                    S_EXEC: begin
                        state_q <= S_IDLE;
                        case (op_q)
                            OP_DUMP: begin
                                if (dump_cnt_d == 16'd0) begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_ZEROCNT;
                                end else if (dump_busy_i) begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_BUSY;
                                end else begin
                                    start_addr_q <= dump_addr_d;
                                    count_q      <= dump_cnt_d;
                                    start_dump_q <= 1'b1;
                                end
                            end
                            OP_ARM:  arm_q <= 1'b1;
                            OP_TRIG: begin
                                trig_mask_q  <= arg_q[0];
                                trig_value_q <= arg_q[1];
                            end
                            default: ;
                        endcase
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign start_dump_o  = start_dump_q;
    assign start_addr_o  = start_addr_q;
    assign count_o       = count_q;
    assign arm_o         = arm_q;
    assign trig_mask_o   = trig_mask_q;
    assign trig_value_o  = trig_value_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign parser_busy_o = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cmd_parser                                                |
// | Description : Self-checking bench for cmd_parser with a frame-level model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cmd_parser;
    import cmd_parser_pkg::*;

    localparam int AW  = 12;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          dump_busy;
    logic          start_dump;
    logic [AW-1:0] start_addr;
    logic [15:0]   count;
    logic          arm;
    logic [7:0]    trig_mask;
    logic [7:0]    trig_value;
    logic          err;
    logic [2:0]    err_code;
    logic          parser_busy;

    cmd_parser #(.AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .dump_busy_i   (dump_busy),
        .start_dump_o  (start_dump),
        .start_addr_o  (start_addr),
        .count_o       (count),
        .arm_o         (arm),
        .trig_mask_o   (trig_mask),
        .trig_value_o  (trig_value),
        .err_o         (err),
        .err_code_o    (err_code),
        .parser_busy_o (parser_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       mon_start, mon_arm, mon_err, mon_cyc, mon_overlap;
    logic [2:0] mon_code;
    initial begin
        mon_start = 0; mon_arm = 0; mon_err = 0; mon_cyc = -1; mon_overlap = 0; mon_code = 0;
    end
    always @(negedge clk) begin
        if (start_dump) begin mon_start++; mon_cyc = cyc; end
        if (arm)        begin mon_arm++;   mon_cyc = cyc; end
        if (err)        begin mon_err++;   mon_cyc = cyc; mon_code = err_code; end
        if (err && (start_dump || arm)) mon_overlap++;
    end

    // Expected architectural state
    logic [AW-1:0] m_addr;
    logic [15:0]   m_count;
    logic [7:0]    m_mask, m_value;
    logic [2:0]    m_code;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_addr = '0; m_count = '0; m_mask = 8'hFF; m_value = '0; m_code = '0;
    endtask

    task automatic clear_mon();
        mon_start = 0; mon_arm = 0; mon_err = 0; mon_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int at);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        at = cyc;
    endtask

    // Builds one frame, predicts its outcome from the protocol rules and checks it.
    task automatic run_frame(input string name, input logic [7:0] op, input logic [31:0] args,
                             input logic [7:0] ckx, input bit busy, input int gap_max,
                             input bit extra_hdr);
        logic [7:0] q[$];
        logic [7:0] a[4];
        logic [7:0] ck;
        logic [15:0] cnt;
        int n, at, exp_start, exp_arm, exp_err, exp_lat;
        bit legal;
        for (int i = 0; i < 4; i++) a[i] = args[8*i +: 8];
        legal = (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
        n  = (op == 8'h01) ? 4 : (op == 8'h03) ? 2 : 0;
        ck = op;
        for (int i = 0; i < n; i++) ck = ck ^ a[i];
        ck = ck ^ ckx;
        exp_start = 0; exp_arm = 0; exp_err = 0; exp_lat = 0;
        if (!legal) begin
            exp_err = 1; m_code = 3'd1;
        end else if (ckx != 8'h00) begin
            exp_err = 1; m_code = 3'd2;
        end else if (op == 8'h01) begin
            cnt = {a[3], a[2]};
            exp_lat = 1;
            if (cnt == 16'd0) begin
                exp_err = 1; m_code = 3'd3;
            end else if (busy) begin
                exp_err = 1; m_code = 3'd4;
            end else begin
                exp_start = 1;
                m_addr  = AW'({a[1], a[0]} % (1 << AW));
                m_count = cnt;
            end
        end else if (op == 8'h02) begin
            exp_arm = 1; exp_lat = 1;
        end else begin
            m_mask = a[0]; m_value = a[1];
        end
        if (extra_hdr) q.push_back(8'h5A);
        q.push_back(8'h5A); q.push_back(8'hC3); q.push_back(op);
        if (legal) begin
            for (int i = 0; i < n; i++) q.push_back(a[i]);
            q.push_back(ck);
        end
        dump_busy = busy;
        clear_mon();
        at = 0;
        foreach (q[i]) begin
            send_byte(q[i], at);
            if (i != q.size() - 1) idle($urandom_range(gap_max, 0));
        end
        idle(5);
        dump_busy = 1'b0;
        n_checks++; if (mon_start !== exp_start) begin n_fail++; $display("FAIL %s start_dump pulses: got %0d want %0d", name, mon_start, exp_start); end
        n_checks++; if (mon_arm !== exp_arm) begin n_fail++; $display("FAIL %s arm pulses: got %0d want %0d", name, mon_arm, exp_arm); end
        n_checks++; if (mon_err !== exp_err) begin n_fail++; $display("FAIL %s err pulses: got %0d want %0d", name, mon_err, exp_err); end
        if (exp_start + exp_arm + exp_err > 0) begin
            n_checks++; if (mon_cyc !== at + exp_lat) begin n_fail++; $display("FAIL %s pulse cycle: got %0d want %0d", name, mon_cyc, at + exp_lat); end
        end
        n_checks++; if (start_addr !== m_addr) begin n_fail++; $display("FAIL %s start_addr: got %h want %h", name, start_addr, m_addr); end
        n_checks++; if (count !== m_count) begin n_fail++; $display("FAIL %s count: got %h want %h", name, count, m_count); end
        n_checks++; if (trig_mask !== m_mask) begin n_fail++; $display("FAIL %s trig_mask: got %h want %h", name, trig_mask, m_mask); end
        n_checks++; if (trig_value !== m_value) begin n_fail++; $display("FAIL %s trig_value: got %h want %h", name, trig_value, m_value); end
        n_checks++; if (err_code !== m_code) begin n_fail++; $display("FAIL %s err_code: got %0d want %0d", name, err_code, m_code); end
        n_checks++; if (parser_busy !== 1'b0) begin n_fail++; $display("FAIL %s parser_busy after frame: got %b want 0", name, parser_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; dump_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++; if ({start_dump, arm, err} !== 3'b000) begin n_fail++; $display("FAIL reset strobes: got %b want 000", {start_dump, arm, err}); end
        n_checks++; if (start_addr !== '0) begin n_fail++; $display("FAIL reset start_addr: got %h want 0", start_addr); end
        n_checks++; if (count !== 16'h0) begin n_fail++; $display("FAIL reset count: got %h want 0", count); end
        n_checks++; if (trig_mask !== 8'hFF) begin n_fail++; $display("FAIL reset trig_mask: got %h want ff", trig_mask); end
        n_checks++; if (trig_value !== 8'h00) begin n_fail++; $display("FAIL reset trig_value: got %h want 0", trig_value); end
        n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset err_code: got %0d want 0", err_code); end
        n_checks++; if (parser_busy !== 1'b0) begin n_fail++; $display("FAIL reset parser_busy: got %b want 0", parser_busy); end
    endtask

    task automatic test_directed();
        run_frame("dump_ok",      8'h01, 32'h0040_0010, 8'h00, 1'b0, 2, 1'b0);
        run_frame("trig",         8'h03, 32'h0000_050F, 8'h00, 1'b0, 2, 1'b0);
        run_frame("arm",          8'h02, 32'h0,         8'h00, 1'b0, 2, 1'b0);
        run_frame("dump_badck",   8'h01, 32'h0040_0010, 8'h01, 1'b0, 2, 1'b0);
        run_frame("bad_op",       8'h07, 32'h0,         8'h00, 1'b0, 0, 1'b0);
        run_frame("arm_after_bo", 8'h02, 32'h0,         8'h00, 1'b0, 0, 1'b0);
        run_frame("dump_zero",    8'h01, 32'h0000_0010, 8'h00, 1'b0, 1, 1'b0);
        run_frame("dump_busy",    8'h01, 32'h0040_0010, 8'h00, 1'b1, 1, 1'b0);
        run_frame("hdr_repeat",   8'h02, 32'h0,         8'h00, 1'b0, 0, 1'b1);
        run_frame("addr_trunc",   8'h01, 32'h0001_F123, 8'h00, 1'b0, 0, 1'b0);
    endtask

    task automatic test_exec_drop();
        int at;
        clear_mon();
        send_byte(8'h5A, at); send_byte(8'hC3, at); send_byte(8'h02, at); send_byte(8'h02, at);
        send_byte(8'h5A, at); send_byte(8'hC3, at); send_byte(8'h02, at); send_byte(8'h02, at);
        idle(5);
        n_checks++; if (mon_arm !== 1) begin n_fail++; $display("FAIL exec_drop arm pulses: got %0d want 1", mon_arm); end
        n_checks++; if (mon_err !== 0) begin n_fail++; $display("FAIL exec_drop err pulses: got %0d want 0", mon_err); end
        clear_mon();
        send_byte(8'h5A, at); send_byte(8'h11, at); send_byte(8'hC3, at); send_byte(8'h02, at); send_byte(8'h02, at);
        idle(5);
        n_checks++; if (mon_arm + mon_err !== 0) begin n_fail++; $display("FAIL h1_abort pulses: got %0d want 0", mon_arm + mon_err); end
    endtask

    task automatic test_timeout();
        int at, waited;
        clear_mon();
        send_byte(8'h5A, at); send_byte(8'hC3, at); send_byte(8'h01, at); send_byte(8'h10, at);
        n_checks++; if (parser_busy !== 1'b1) begin n_fail++; $display("FAIL timeout busy mid-frame: got %b want 1", parser_busy); end
        waited = 0;
        while (mon_err == 0 && waited < TMO + 10) begin idle(1); waited++; end
        idle(2);
        m_code = 3'd5;
        n_checks++; if (mon_err !== 1) begin n_fail++; $display("FAIL timeout err pulses: got %0d want 1", mon_err); end
        n_checks++; if (mon_cyc !== at + TMO) begin n_fail++; $display("FAIL timeout pulse cycle: got %0d want %0d", mon_cyc, at + TMO); end
        n_checks++; if (err_code !== m_code) begin n_fail++; $display("FAIL timeout err_code: got %0d want %0d", err_code, m_code); end
        n_checks++; if (parser_busy !== 1'b0) begin n_fail++; $display("FAIL timeout busy after: got %b want 0", parser_busy); end
        run_frame("after_timeout", 8'h02, 32'h0, 8'h00, 1'b0, 3, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] op, ckx;
        logic [31:0] args;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(9, 0) < 7) op = 8'($urandom_range(3, 1));
            else begin
                op = 8'($urandom);
                while (op >= 8'h01 && op <= 8'h03) op = 8'($urandom);
            end
            args = $urandom;
            if (op == 8'h01 && $urandom_range(5, 0) == 0) args[31:16] = 16'h0;
            ckx = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_frame("random", op, args, ckx, ($urandom_range(3, 0) == 0), 3, ($urandom_range(7, 0) == 0));
        end
    endtask

    task automatic test_reset_midframe();
        int at;
        clear_mon();
        send_byte(8'h5A, at); send_byte(8'hC3, at);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        send_byte(8'h02, at); send_byte(8'h02, at);
        idle(5);
        n_checks++; if (mon_arm + mon_err + mon_start !== 0) begin n_fail++; $display("FAIL midreset pulses: got %0d want 0", mon_arm + mon_err + mon_start); end
        n_checks++; if (trig_mask !== m_mask) begin n_fail++; $display("FAIL midreset trig_mask: got %h want %h", trig_mask, m_mask); end
        n_checks++; if (err_code !== m_code) begin n_fail++; $display("FAIL midreset err_code: got %0d want %0d", err_code, m_code); end
        n_checks++; if (start_addr !== m_addr) begin n_fail++; $display("FAIL midreset start_addr: got %h want %h", start_addr, m_addr); end
    endtask

    task automatic test_no_overlap();
        n_checks++; if (mon_overlap !== 0) begin n_fail++; $display("FAIL err_strobe_overlap: got %0d want 0", mon_overlap); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exec_drop();
        test_timeout();
        test_random();
        test_reset_midframe();
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
